id_issue_ctrl: RTL and testbench

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/imm_gen.sv | 33 +++
 rtl/id_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_id_issue_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the issue-stage FSM encoding.
// Used by the decode/issue control block and its immediate generator.
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // addi x0,x0,0 -- what the issue port shows when nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        ISSUE  = 1'b0,
        BUBBLE = 1'b1
    } issue_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_REG)  || (opcode == OP_STORE) || (opcode == OP_BRANCH) ||
               (opcode == OP_IMM)  || (opcode == OP_LOAD)  || (opcode == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational sign-extended immediate extraction for RV32 base formats.
// Formats without an immediate (R-type, unknown opcodes) produce zero.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 64
) (
    input  logic [31:0]          instr,
    output logic [REG_WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm = REG_WIDTH'($signed(imm32));
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode/issue control: 2-entry fetch buffer, load-use bubble insertion,
// flush handling and a saturating bubble counter.
module id_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_valid,
    output logic                 f_ready,
    input  logic [31:0]          f_instr,
    input  logic [REG_WIDTH-1:0] f_pc,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic [31:0]          d_instr,
    output logic [REG_WIDTH-1:0] d_pc,
    output logic [REG_WIDTH-1:0] d_imm,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd,
    input  logic                 flush,
    output logic [31:0]          stall_cnt,
    output logic                 dbg_state
);

    // Handshake: a word moves on any cycle where valid && ready are both high.
    // Fetch side: f_ready is never offered while full or flushing. Issue side:
    // once d_valid is raised it holds with the same head until d_ready is seen.

    logic [1:0]           count;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [31:0]          mem_instr [2];
    logic [REG_WIDTH-1:0] mem_pc    [2];

    issue_state_t state;
    issue_state_t state_next;

    logic       push;
    logic       pop;
    logic       hazard;
    logic       stall_inc;
    logic [6:0] head_op;
    logic [4:0] head_rs1;
    logic [4:0] head_rs2;

    always_comb begin
        d_instr = NOP_INSTR;
        d_pc    = '0;
        if (count != 2'd0) begin
            d_instr = mem_instr[rd_ptr];
            d_pc    = mem_pc[rd_ptr];
        end
    end

    imm_gen #(
        .REG_WIDTH(REG_WIDTH)
    ) u_imm_gen (
        .instr(d_instr),
        .imm  (d_imm)
    );

    assign head_op  = d_instr[6:0];
    assign head_rs1 = d_instr[19:15];
    assign head_rs2 = d_instr[24:20];

    assign hazard = ex_mem_read && (ex_rd != 5'd0) && (count != 2'd0) &&
                    ((uses_rs1(head_op) && (head_rs1 == ex_rd)) ||
                     (uses_rs2(head_op) && (head_rs2 == ex_rd)));

    // rst gates f_ready directly so nothing is offered while reset is held.
    assign f_ready = !rst && (count < 2'd2) && !flush;

    always_comb begin
        state_next = state;
        d_valid    = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            ISSUE: begin
                if (hazard) begin
                    stall_inc = 1'b1;
                    if (!flush) state_next = BUBBLE;
                end else if ((count != 2'd0) && !flush) begin
                    d_valid = 1'b1;
                end
            end
            BUBBLE: begin
                stall_inc  = 1'b1;
                state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
        if (flush) state_next = ISSUE;
    end

    assign push      = f_valid && f_ready;
    assign pop       = d_valid && d_ready;
    assign dbg_state = (state == BUBBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= f_instr;
            mem_pc[wr_ptr]    <= f_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: issue, load-use bubble, backpressure,
// flush and asynchronous reset, each with hand-computed expectations.
module tb_id_issue_ctrl;

    localparam int W = 64;

    localparam logic [31:0] ADDI_5   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] ADD_3_21 = 32'h001101B3; // add x3,x2,x1
    localparam logic [31:0] LUI_X2   = 32'h12345137; // lui x2,0x12345
    localparam logic [31:0] ADDI_M1  = 32'hFFF10093; // addi x1,x2,-1
    localparam logic [31:0] ADDI_7   = 32'h00700093; // addi x1,x0,7
    localparam logic [31:0] NOP      = 32'h00000013;

    logic         clk;
    logic         rst;
    logic         f_valid;
    logic         f_ready;
    logic [31:0]  f_instr;
    logic [W-1:0] f_pc;
    logic         d_valid;
    logic         d_ready;
    logic [31:0]  d_instr;
    logic [W-1:0] d_pc;
    logic [W-1:0] d_imm;
    logic         ex_mem_read;
    logic [4:0]   ex_rd;
    logic         flush;
    logic [31:0]  stall_cnt;
    logic         dbg_state;

    int total;
    int bad;

    id_issue_ctrl #(.REG_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_imm      (d_imm),
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .stall_cnt  (stall_cnt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_f_ready"},   W'(f_ready),   '0);
        chk({tag, "_d_valid"},   W'(d_valid),   '0);
        chk({tag, "_d_instr"},   W'(d_instr),   W'(NOP));
        chk({tag, "_d_pc"},      d_pc,          '0);
        chk({tag, "_d_imm"},     d_imm,         '0);
        chk({tag, "_stall_cnt"}, W'(stall_cnt), '0);
        chk({tag, "_state"},     W'(dbg_state), '0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        f_valid = 1'b0;
        f_instr = '0;
        f_pc = '0;
        d_ready = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd = '0;
        flush = 1'b0;

        // reset state
        #1;
        chk_reset_vals("rst");
        step();
        step();
        rst = 1'b0;
        #1;

        // single addi issues the cycle after it is pushed
        f_valid = 1'b1; f_instr = ADDI_5; f_pc = 64'h100; d_ready = 1'b1;
        #1;
        chk("p1_f_ready", W'(f_ready), 1);
        chk("p1_d_valid_empty", W'(d_valid), 0);
        step();
        f_valid = 1'b0;
        #1;
        chk("p1_d_valid", W'(d_valid), 1);
        chk("p1_d_instr", W'(d_instr), W'(ADDI_5));
        chk("p1_d_pc", d_pc, 64'h100);
        chk("p1_d_imm", d_imm, 64'd5);
        step();
        chk("p1_drained", W'(d_valid), 0);
        chk("p1_nop", W'(d_instr), W'(NOP));

        // load-use hazard on rs1 = x2
        f_valid = 1'b1; f_instr = ADD_3_21; f_pc = 64'h104;
        step();
        f_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd2;
        #1;
        chk("lu_hazard_d_valid", W'(d_valid), 0);
        chk("lu_hazard_stall0", W'(stall_cnt), 0);
        chk("lu_hazard_state", W'(dbg_state), 0);
        step();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        #1;
        chk("lu_bubble_state", W'(dbg_state), 1);
        chk("lu_bubble_stall1", W'(stall_cnt), 1);
        chk("lu_bubble_d_valid", W'(d_valid), 0);
        chk("lu_bubble_head", W'(d_instr), W'(ADD_3_21));
        step();
        chk("lu_issue_state", W'(dbg_state), 0);
        chk("lu_issue_d_valid", W'(d_valid), 1);
        chk("lu_issue_d_pc", d_pc, 64'h104);
        chk("lu_issue_stall", W'(stall_cnt), 2);
        step();

        // ex_rd = 0 never hazards
        f_valid = 1'b1; f_instr = ADD_3_21; f_pc = 64'h108;
        step();
        f_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd0;
        #1;
        chk("rd0_d_valid", W'(d_valid), 1);
        step();
        chk("rd0_stall", W'(stall_cnt), 2);
        chk("rd0_state", W'(dbg_state), 0);

        // lui reads no source register
        f_valid = 1'b1; f_instr = LUI_X2; f_pc = 64'h10C; ex_rd = 5'd2;
        step();
        f_valid = 1'b0;
        #1;
        chk("lui_d_valid", W'(d_valid), 1);
        chk("lui_d_imm", d_imm, 64'h0000_0000_1234_5000);
        step();
        chk("lui_stall", W'(stall_cnt), 2);
        chk("lui_state", W'(dbg_state), 0);
        ex_mem_read = 1'b0; ex_rd = 5'd0;

        // backpressure: fill two entries with d_ready low
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = ADDI_5; f_pc = 64'h200;
        #1;
        chk("bp_f_ready0", W'(f_ready), 1);
        step();
        f_instr = ADDI_M1; f_pc = 64'h204;
        #1;
        chk("bp_f_ready1", W'(f_ready), 1);
        chk("bp_head0", d_pc, 64'h200);
        step();
        f_instr = LUI_X2; f_pc = 64'h208;
        #1;
        chk("bp_full_f_ready", W'(f_ready), 0);
        chk("bp_full_d_valid", W'(d_valid), 1);
        step();
        chk("bp_hold_f_ready", W'(f_ready), 0);
        chk("bp_hold_d_valid", W'(d_valid), 1);
        chk("bp_hold_pc", d_pc, 64'h200);
        f_valid = 1'b0; d_ready = 1'b1;
        #1;
        chk("bp_pop_cycle_f_ready", W'(f_ready), 0);
        step();
        chk("bp_after_pop_f_ready", W'(f_ready), 1);
        chk("bp_second_pc", d_pc, 64'h204);
        chk("bp_second_imm", d_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bp_second_valid", W'(d_valid), 1);
        step();
        chk("bp_empty", W'(d_valid), 0);

        // flush with two entries and a concurrent push
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = ADDI_5; f_pc = 64'h280;
        step();
        f_pc = 64'h284;
        step();
        flush = 1'b1; f_instr = ADDI_7; f_pc = 64'h300; d_ready = 1'b1;
        #1;
        chk("fl_f_ready", W'(f_ready), 0);
        chk("fl_d_valid", W'(d_valid), 0);
        step();
        flush = 1'b0; f_valid = 1'b0;
        #1;
        chk("fl_post_d_valid", W'(d_valid), 0);
        chk("fl_post_instr", W'(d_instr), W'(NOP));
        chk("fl_post_f_ready", W'(f_ready), 1);
        step();
        chk("fl_no_issue", W'(d_valid), 0);

        // async reset while in BUBBLE with one entry
        f_valid = 1'b1; f_instr = ADD_3_21; f_pc = 64'h400;
        step();
        f_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd1;
        step();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        #1;
        chk("ar_state", W'(dbg_state), 1);
        chk("ar_stall", W'(stall_cnt), 3);
        chk("ar_head", d_pc, 64'h400);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("ar");
        step();
        rst = 1'b0;
        #1;
        chk("ar_released_empty", W'(d_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
